// File: rtl/mips_run_controller.sv
// Run/stop/single-step sequencer for the four-phase MIPS core: phase counter, pause, breakpoints.
// Define RUNCTL_ICOUNT_EN to build the retired-instruction counter; otherwise icount reads 0.
module mips_run_controller #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             prg_mode,
  input  logic             core_rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic [1:0]       phase,
  output logic             pause,
  output logic             retire,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_HALT = 2'd2;
  localparam logic [1:0] CMD_STEP = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       retire_d;
  logic       stop_pending_q, stop_pending_d;
  logic       bp_skip_q, bp_skip_d;

  logic running, adv, bp_hit, adv_eff, retire_now, cmd_fire;

  // Cycle qualifiers, all from pre-command registered state
  assign running    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign adv        = tick & ~prg_mode & ~core_rst & running;
  assign bp_hit     = ~prg_mode & ~core_rst & (state_q == ST_RUN) & (phase_q == 2'd0)
                    & bp_en & (pc == bp_addr) & ~bp_skip_q;
  assign adv_eff    = adv & ~bp_hit;
  assign retire_now = adv_eff & (phase_q == 2'd3);
  assign cmd_ready  = ~prg_mode & ~core_rst & (state_q != ST_STEP);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign pause      = ~running | prg_mode;
  assign phase      = phase_q;
  assign status     = 2'(state_q);

  // Next state: core_rst, then retire transition, then breakpoint, then command
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    stop_pending_d = stop_pending_q;
    bp_skip_d      = bp_skip_q;
    retire_d       = 1'b0;
    if (core_rst) begin
      state_d        = ST_HALT;
      phase_d        = 2'd0;
      stop_pending_d = 1'b0;
      bp_skip_d      = 1'b0;
    end else if (!prg_mode) begin
      if (adv_eff) phase_d = 2'(phase_q + 2'd1);
      retire_d = retire_now;
      if (retire_now) bp_skip_d = 1'b0;
      if (retire_now && ((state_q == ST_STEP) || stop_pending_q)) begin
        state_d        = ST_HALT;
        stop_pending_d = 1'b0;
      end else if (bp_hit) begin
        state_d        = ST_BREAK;
        stop_pending_d = 1'b0;
      end else if (cmd_fire) begin
        case (state_q)
          ST_HALT: begin
            if (cmd == CMD_RUN)  state_d = ST_RUN;
            if (cmd == CMD_STEP) state_d = ST_STEP;
          end
          ST_RUN: begin
            if (cmd == CMD_HALT) begin
              if ((phase_q == 2'd0) && !adv_eff) begin
                state_d        = ST_HALT;
                stop_pending_d = 1'b0;
              end else begin
                stop_pending_d = 1'b1;
              end
            end
          end
          ST_BREAK: begin
            case (cmd)
              CMD_RUN:  begin state_d = ST_RUN;  bp_skip_d = 1'b1; end
              CMD_STEP: begin state_d = ST_STEP; bp_skip_d = 1'b1; end
              CMD_HALT: state_d = ST_HALT;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_HALT;
      phase_q        <= 2'd0;
      retire         <= 1'b0;
      stop_pending_q <= 1'b0;
      bp_skip_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      retire         <= retire_d;
      stop_pending_q <= stop_pending_d;
      bp_skip_q      <= bp_skip_d;
    end
  end

`ifdef RUNCTL_ICOUNT_EN
  // Survives core_rst; only the power-on reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icount <= '0;
    else if (!core_rst && !prg_mode && retire_now) icount <= CNT_W'(icount + CNT_W'(1));
  end
`else
  assign icount = '0;
`endif

endmodule
